// File: rtl/spi_pkg.sv
// spi_pkg: constants shared by the SPI front end and its input conditioners.
`default_nettype none

package spi_pkg;

   localparam int DEBOUNCE_WAIT_DEFAULT = 3;
   localparam int DEBOUNCE_CNT_W        = 3;

   // The counter must be able to hold WAIT_TIME-1 and WAIT_TIME must be at least 1.
   function automatic bit debounce_wait_legal(input int wait_cycles, input int cnt_w);
      return (wait_cycles >= 1) && (wait_cycles <= (2 ** cnt_w) - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync2ff.sv
// sync2ff: two-flop synchronizer for one asynchronous pin, synchronous active-low reset.
`default_nettype none

module sync2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
      end
   end

   assign q_o = sync2_q;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes, debounces one pin and emits level plus edge strobes.
`default_nettype none

module input_conditioner
   import spi_pkg::*;
#(
   parameter int COUNTER_WIDTH = DEBOUNCE_CNT_W,
   parameter int WAIT_TIME     = DEBOUNCE_WAIT_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic noisysignal,
   output logic conditioned,
   output logic positiveedge,
   output logic negativeedge
);

   generate
      if (!debounce_wait_legal(WAIT_TIME, COUNTER_WIDTH)) begin : g_bad_wait_time
         $error("input_conditioner: WAIT_TIME must be in 1 .. 2**COUNTER_WIDTH-1");
      end
   endgenerate

   localparam logic [COUNTER_WIDTH-1:0] c_cnt_last = COUNTER_WIDTH'(WAIT_TIME - 1);

   logic                     sync_w;
   logic [COUNTER_WIDTH-1:0] cnt_q;
   logic [COUNTER_WIDTH-1:0] cnt_d;
   logic                     cond_q;
   logic                     cond_d;
   logic                     pos_q;
   logic                     pos_d;
   logic                     neg_q;
   logic                     neg_d;

   sync2ff u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (noisysignal),
      .q_o     (sync_w)
   );

   // Any agreeing sample clears the count; a disagreement must persist WAIT_TIME edges.
   always_comb begin
      cond_d = cond_q;
      cnt_d  = '0;
      pos_d  = 1'b0;
      neg_d  = 1'b0;
      if (sync_w != cond_q) begin
         if (cnt_q == c_cnt_last) begin
            cond_d = sync_w;
            pos_d  = sync_w;
            neg_d  = ~sync_w;
         end else begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         cond_q <= 1'b0;
         pos_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         cond_q <= cond_d;
         pos_q  <= pos_d;
         neg_q  <= neg_d;
      end
   end

   assign conditioned  = cond_q;
   assign positiveedge = pos_q;
   assign negativeedge = neg_q;

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenarios plus randomized traffic against a window-based model.
`default_nettype none

module tb_input_conditioner;
   import spi_pkg::*;

   localparam int WT = DEBOUNCE_WAIT_DEFAULT;

   logic clk         = 1'b0;
   logic reset_n     = 1'b0;
   logic noisysignal = 1'b0;
   logic conditioned;
   logic positiveedge;
   logic negativeedge;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   input_conditioner dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .noisysignal  (noisysignal),
      .conditioned  (conditioned),
      .positiveedge (positiveedge),
      .negativeedge (negativeedge)
   );

   // Reference: the level flips once the last WT debounce-visible samples (the pin
   // as sampled two edges earlier) all disagree with the current level.
   bit m_cond, m_pos, m_neg;
   bit hist[$];
   always @(posedge clk) begin
      int  idx;
      bit  s;
      bit  all_diff;
      if (!reset_n) begin
         hist.delete();
         m_cond = 1'b0;
         m_pos  = 1'b0;
         m_neg  = 1'b0;
      end else begin
         hist.push_back(noisysignal);
         if (hist.size() > 16) void'(hist.pop_front());
         m_pos    = 1'b0;
         m_neg    = 1'b0;
         all_diff = 1'b1;
         for (int j = 0; j < WT; j++) begin
            idx = hist.size() - 3 - j;
            s   = (idx >= 0) ? hist[idx] : 1'b0;
            if (s == m_cond) all_diff = 1'b0;
         end
         if (all_diff) begin
            m_cond = !m_cond;
            if (m_cond) m_pos = 1'b1;
            else        m_neg = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input logic v, input int n);
      noisysignal = v;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      noisysignal = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({conditioned, positiveedge, negativeedge} !== 3'b000)
         $display("FAIL reset_state: got %b expected 000", {conditioned, positiveedge, negativeedge});
      else n_pass++;
      reset_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         n_checks++;
         if (conditioned !== (e >= WT + 2))
            $display("FAIL reset_release_cond edge %0d: got %b expected %b", e, conditioned, (e >= WT + 2));
         else n_pass++;
         n_checks++;
         if (positiveedge !== (e == WT + 2))
            $display("FAIL reset_release_pos edge %0d: got %b expected %b", e, positiveedge, (e == WT + 2));
         else n_pass++;
         n_checks++;
         if (negativeedge !== 1'b0)
            $display("FAIL reset_release_neg edge %0d: got %b expected 0", e, negativeedge);
         else n_pass++;
      end
   endtask

   task automatic test_rise();
      settle(1'b0, 8);
      noisysignal = 1'b1;
      for (int e = 0; e <= 5; e++) begin
         tick();
         n_checks++;
         if (conditioned !== (e >= WT + 1))
            $display("FAIL rise_cond k+%0d: got %b expected %b", e, conditioned, (e >= WT + 1));
         else n_pass++;
         n_checks++;
         if ({positiveedge, negativeedge} !== {(e == WT + 1), 1'b0})
            $display("FAIL rise_strobes k+%0d: got %b expected %b", e, {positiveedge, negativeedge}, {(e == WT + 1), 1'b0});
         else n_pass++;
      end
   endtask

   task automatic test_glitch();
      settle(1'b0, 8);
      for (int e = 0; e < 10; e++) begin
         noisysignal = (e < 2);
         tick();
         n_checks++;
         if ({conditioned, positiveedge, negativeedge} !== 3'b000)
            $display("FAIL glitch edge %0d: got %b expected 000", e, {conditioned, positiveedge, negativeedge});
         else n_pass++;
      end
   endtask

   task automatic test_bounce();
      bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      int pos_count = 0;
      settle(1'b0, 8);
      for (int e = 0; e < 12; e++) begin
         noisysignal = (e < 6) ? pat[e] : 1'b1;
         tick();
         if (positiveedge) pos_count++;
         // Last 0->1 sample is at edge 2, so the level rises WT+1 edges later.
         n_checks++;
         if ({conditioned, positiveedge, negativeedge} !== {(e >= 2 + WT + 1), (e == 2 + WT + 1), 1'b0})
            $display("FAIL bounce edge %0d: got %b expected %b", e, {conditioned, positiveedge, negativeedge},
                     {(e >= 2 + WT + 1), (e == 2 + WT + 1), 1'b0});
         else n_pass++;
      end
      n_checks++;
      if (pos_count != 1) $display("FAIL bounce_strobe_count: got %0d expected 1", pos_count);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      settle(1'b1, 8);
      noisysignal = 1'b0;
      repeat (4) tick();
      n_checks++;
      if ({conditioned, negativeedge} !== 2'b10)
         $display("FAIL mid_before_reset: got %b expected 10", {conditioned, negativeedge});
      else n_pass++;
      reset_n = 1'b0;
      tick();
      n_checks++;
      if ({conditioned, positiveedge, negativeedge} !== 3'b000)
         $display("FAIL mid_reset: got %b expected 000", {conditioned, positiveedge, negativeedge});
      else n_pass++;
      reset_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         n_checks++;
         if ({conditioned, positiveedge, negativeedge} !== 3'b000)
            $display("FAIL mid_after_release edge %0d: got %b expected 000", e, {conditioned, positiveedge, negativeedge});
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int strobes = 0;
      settle(1'b1, 8);
      noisysignal = 1'b0;
      for (int e = 0; e <= WT + 1; e++) begin
         tick();
         strobes += int'(positiveedge) + int'(negativeedge);
         n_checks++;
         if ({conditioned, negativeedge} !== {(e < WT + 1), (e == WT + 1)})
            $display("FAIL b2b_fall k+%0d: got %b expected %b", e, {conditioned, negativeedge}, {(e < WT + 1), (e == WT + 1)});
         else n_pass++;
      end
      noisysignal = 1'b1;
      for (int e = 0; e <= WT + 2; e++) begin
         tick();
         strobes += int'(positiveedge) + int'(negativeedge);
         n_checks++;
         if ({conditioned, positiveedge, negativeedge} !== {(e >= WT + 1), (e == WT + 1), 1'b0})
            $display("FAIL b2b_rise k+%0d: got %b expected %b", e, {conditioned, positiveedge, negativeedge},
                     {(e >= WT + 1), (e == WT + 1), 1'b0});
         else n_pass++;
      end
      n_checks++;
      if (strobes != 2) $display("FAIL b2b_strobe_count: got %0d expected 2", strobes);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         int hold = $urandom_range(1, 6);
         noisysignal = 1'($urandom_range(0, 1));
         reset_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
         for (int h = 0; h < hold; h++) begin
            tick();
            reset_n = 1'b1;
            n_checks++;
            if ({conditioned, positiveedge, negativeedge} !== {m_cond, m_pos, m_neg})
               $display("FAIL random iter %0d: got %b expected %b", i, {conditioned, positiveedge, negativeedge},
                        {m_cond, m_pos, m_neg});
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_glitch();
      test_bounce();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
